xarb_rr: RTL

- N-input round-robin arbiter with packet locking. It sits directly upstream of the XHs handshake register at each switch output port.
- It selects one of NUM_IN valid/ready request streams and forwards its data and last flag combinationally to the output register stage.
- The grant is held from first offer until the end-of-packet flit transfers, so packets are never interleaved.

---
 rtl/xarb_rr.sv | 112 +++++++++++
 1 files changed

// File: rtl/xarb_rr.sv
// Round-robin arbiter with packet locking: picks one of NUM_IN valid/ready streams
// and holds the grant from first offer until the last flit of that packet transfers.

module xarb_rr_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic [ID_W-1:0] sel,
  input  logic            xfer_en,
  output logic            rdy
);
  assign rdy = xfer_en && (sel == ID_W'(LANE));
endmodule

module xarb_rr #(
  parameter  int NUM_IN  = 4,
  parameter  int D_WIDTH = 16,
  localparam int ID_W    = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_IN-1:0]         vldi,
  input  logic [NUM_IN-1:0]         lasti,
  input  logic [NUM_IN*D_WIDTH-1:0] datai,
  output logic [NUM_IN-1:0]         rdyi,
  output logic                      vldo,
  output logic                      lasto,
  output logic [D_WIDTH-1:0]        datao,
  output logic [ID_W-1:0]           gnt,
  input  logic                      rdyo
);

  typedef enum logic {IDLE, LOCKED} st_e;

  st_e             st_q, st_d;
  logic [ID_W-1:0] ptr_q, ptr_d, lock_q, lock_d;
  logic [ID_W-1:0] rr_sel, sel, sel_inc;
  logic            rr_hit, xfer_en;

  // Rotating-priority search starting at ptr; falls back to ptr when nothing is valid.
  always_comb begin
    int idx;
    idx    = 0;
    rr_sel = ptr_q;
    rr_hit = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!rr_hit && vldi[idx]) begin
        rr_hit = 1'b1;
        rr_sel = ID_W'(idx);
      end
    end
  end

  assign sel     = (st_q == LOCKED) ? lock_q : rr_sel;
  assign sel_inc = (sel == ID_W'(NUM_IN - 1)) ? '0 : sel + ID_W'(1);

  // Reset gates the handshake combinationally so nothing leaks out while rstn is low.
  assign vldo    = rstn && vldi[sel];
  assign lasto   = lasti[sel];
  assign datao   = datai[int'(sel)*D_WIDTH +: D_WIDTH];
  assign gnt     = sel;
  assign xfer_en = vldo && rdyo;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    xarb_rr_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
      .sel     (sel),
      .xfer_en (xfer_en),
      .rdy     (rdyi[i])
    );
  end

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    case (st_q)
      IDLE: begin
        if (vldo) begin
          if (rdyo && lasto) begin
            ptr_d = sel_inc;
          end else begin
            // Unaccepted offers lock too, keeping the offered flit stable under stall.
            st_d   = LOCKED;
            lock_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer_en && lasto) begin
          st_d  = IDLE;
          ptr_d = sel_inc;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      ptr_q  <= '0;
      lock_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
    end
  end

endmodule
